// File: rtl/spi_transmit_scheduler.sv
// Round-robin scheduler that shares one SPI transmitter between two requesters,
// sequencing load/ss/sclk. Optional abort port: define SPI_TRANSMIT_SCHEDULER_ABORT_EN.
module spi_transmit_scheduler #(
    parameter int   bitcount      = 16,
    parameter int   clock_divider = 4,
    parameter int   setup_cycles  = 2,
    parameter int   gap_cycles    = 4,
    parameter logic ss_polarity   = 1'b0,
    parameter logic sclk_polarity = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [bitcount-1:0] data0,
    input  logic [bitcount-1:0] data1,
`ifdef SPI_TRANSMIT_SCHEDULER_ABORT_EN
    input  logic                abort,
`endif
    output logic                grant0,
    output logic                grant1,
    output logic [bitcount-1:0] data,
    output logic                load,
    output logic                ss,
    output logic                sclk,
    output logic                busy,
    output logic                done,
    output logic                channel
);

    localparam int CMAX_A = (clock_divider > setup_cycles) ? clock_divider : setup_cycles;
    localparam int CMAX   = (CMAX_A > gap_cycles) ? CMAX_A : gap_cycles;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int TW     = $clog2(2 * bitcount + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [bitcount-1:0] data_q, data_d;
    logic                channel_q, channel_d;
    logic                last_q, last_d;
    logic                grant0_q, grant0_d;
    logic                grant1_q, grant1_d;
    logic                load_q, load_d;
    logic                ss_q, ss_d;
    logic                sclk_q, sclk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                abort_hit;
    logic                pick;

`ifdef SPI_TRANSMIT_SCHEDULER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        tcnt_d    = tcnt_q;
        data_d    = data_q;
        channel_d = channel_q;
        last_d    = last_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        aborted_d = aborted_q;
        // On a tie the channel not served last wins; last_q resets to 1 so channel 0 wins first.
        pick      = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                tcnt_d    = '0;
                aborted_d = 1'b0;
                if (req0 || req1) begin
                    grant0_d  = ~pick;
                    grant1_d  = pick;
                    data_d    = pick ? data1 : data0;
                    channel_d = pick;
                    last_d    = pick;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(setup_cycles - 1)) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(clock_divider - 1)) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TW'(2 * bitcount - 1)) begin
                        tcnt_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CW'(clock_divider - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == CW'(gap_cycles - 1)) begin
                    cnt_d   = '0;
                    done_d  = ~aborted_q;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (abort_hit && (state_q == SETUP || state_q == SHIFT || state_q == HOLD)) begin
            state_d   = GAP;
            cnt_d     = '0;
            tcnt_d    = '0;
            sclk_d    = sclk_polarity;
            aborted_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        ss_d   = (state_d == SETUP || state_d == SHIFT || state_d == HOLD) ? ss_polarity : ~ss_polarity;
        load_d = (state_d == LOAD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            data_q    <= '0;
            channel_q <= 1'b0;
            last_q    <= 1'b1;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            load_q    <= 1'b0;
            ss_q      <= ~ss_polarity;
            sclk_q    <= sclk_polarity;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            data_q    <= data_d;
            channel_q <= channel_d;
            last_q    <= last_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            load_q    <= load_d;
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant0  = grant0_q;
    assign grant1  = grant1_q;
    assign data    = data_q;
    assign load    = load_q;
    assign ss      = ss_q;
    assign sclk    = sclk_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign channel = channel_q;

endmodule
